// File: rtl/core_inst_seq.sv
// Instruction sequencer for one attention-score pass on the single-core datapath.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt / stall_cnt performance counters.
module core_inst_seq #(
    parameter int bw  = 8,
    parameter int pr  = 16,
    parameter int col = 8,
    parameter int len = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [pr*bw-1:0] mem_in,
    output logic [pr*bw-1:0] mem_out,
    input  logic             fifo_valid,
    output logic [18:0]      inst,
    output logic             busy,
    output logic             done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      cycle_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [4:0] LEN_N = 5'(len);
    localparam logic [4:0] COL_N = 5'(col);

    typedef enum logic [3:0] {
        IDLE,
        QLOAD,
        KLOAD,
        KPRE,
        EXEC,
        DRAIN,
        ACC,
        DIV,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [4:0]  rcnt, rcnt_n;
    logic [4:0]  wcnt, wcnt_n;
    logic        rd_d, rd_n;
    logic        ph, ph_n;
    logic        accept;
    logic [18:0] inst_n;

    assign in_ready = (state == QLOAD) || (state == KLOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rcnt    <= '0;
            wcnt    <= '0;
            rd_d    <= 1'b0;
            ph      <= 1'b0;
            inst    <= '0;
            mem_out <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rcnt  <= rcnt_n;
            wcnt  <= wcnt_n;
            rd_d  <= rd_n;
            ph    <= ph_n;
            inst  <= inst_n;
            if (accept) begin
                mem_out <= mem_in;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rcnt_n  = rcnt;
        wcnt_n  = wcnt;
        rd_n    = 1'b0;
        ph_n    = ph;
        accept  = 1'b0;
        inst_n  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = QLOAD;
                    cnt_n   = '0;
                end
            end
            QLOAD: begin
                if (in_valid) begin
                    accept         = 1'b1;
                    inst_n[4]      = 1'b1;
                    inst_n[15:12]  = cnt[3:0];
                    if (cnt == LEN_N - 5'd1) begin
                        state_n = KLOAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            KLOAD: begin
                if (in_valid) begin
                    accept         = 1'b1;
                    inst_n[2]      = 1'b1;
                    inst_n[15:12]  = cnt[3:0];
                    if (cnt == COL_N - 5'd1) begin
                        state_n = KPRE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            // Load/execute flags trail the SRAM read by one cycle.
            KPRE: begin
                if (cnt < COL_N) begin
                    inst_n[3]     = 1'b1;
                    inst_n[15:12] = cnt[3:0];
                end
                inst_n[6] = (cnt != 5'd0);
                if (cnt == COL_N) begin
                    state_n = EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            EXEC: begin
                if (cnt < LEN_N) begin
                    inst_n[5]     = 1'b1;
                    inst_n[15:12] = cnt[3:0];
                end
                inst_n[7] = (cnt != 5'd0);
                if (cnt == LEN_N) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                    rcnt_n  = '0;
                    wcnt_n  = '0;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            DRAIN: begin
                if (fifo_valid && (rcnt < LEN_N)) begin
                    inst_n[16] = 1'b1;
                    rd_n       = 1'b1;
                    rcnt_n     = rcnt + 5'd1;
                end
                // The row popped last cycle is written to PSUM now.
                if (rd_d) begin
                    inst_n[0]    = 1'b1;
                    inst_n[11:8] = wcnt[3:0];
                    wcnt_n       = wcnt + 5'd1;
                    if (wcnt == LEN_N - 5'd1) begin
                        state_n = ACC;
                        cnt_n   = '0;
                    end
                end
            end
            ACC: begin
                if (cnt < LEN_N) begin
                    inst_n[1]    = 1'b1;
                    inst_n[11:8] = cnt[3:0];
                end
                inst_n[17] = (cnt != 5'd0);
                if (cnt == LEN_N) begin
                    state_n = DIV;
                    cnt_n   = '0;
                    ph_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            DIV: begin
                inst_n[11:8] = cnt[3:0];
                if (!ph) begin
                    inst_n[1] = 1'b1;
                    ph_n      = 1'b1;
                end else begin
                    inst_n[18] = 1'b1;
                    inst_n[0]  = 1'b1;
                    ph_n       = 1'b0;
                    if (cnt == LEN_N - 5'd1) begin
                        state_n = DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic stall;

    assign stall = (in_ready && !in_valid) ||
                   ((state == DRAIN) && !fifo_valid && (rcnt < LEN_N));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && (cycle_cnt != 16'hFFFF)) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed self-checking bench for core_inst_seq.
// Builds with or without SEQ_PERF_CNT_EN.
module tb_core_inst_seq;

    localparam int BW  = 8;
    localparam int PR  = 16;
    localparam int COL = 8;
    localparam int LEN = 8;

    localparam logic [18:0] SD  = 19'h40000;
    localparam logic [18:0] SA  = 19'h20000;
    localparam logic [18:0] OFR = 19'h10000;
    localparam logic [18:0] EX  = 19'h00080;
    localparam logic [18:0] KL  = 19'h00040;
    localparam logic [18:0] QR  = 19'h00020;
    localparam logic [18:0] QW  = 19'h00010;
    localparam logic [18:0] KR  = 19'h00008;
    localparam logic [18:0] KW  = 19'h00004;
    localparam logic [18:0] PRD = 19'h00002;
    localparam logic [18:0] PW  = 19'h00001;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [PR*BW-1:0] mem_in;
    logic [PR*BW-1:0] mem_out;
    logic             fifo_valid;
    logic [18:0]      inst;
    logic             busy;
    logic             done;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]      cycle_cnt;
    logic [15:0]      stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_inst_seq #(.bw(BW), .pr(PR), .col(COL), .len(LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_in     (mem_in),
        .mem_out    (mem_out),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    function automatic logic [18:0] qa(input int a);
        return 19'(a) << 12;
    endfunction

    function automatic logic [18:0] pa(input int a);
        return 19'(a) << 8;
    endfunction

    function automatic logic [127:0] vec(input int i);
        logic [7:0] b;
        b = 8'(i * 29 + 5);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk19(input string tag, input logic [18:0] obs,
                         input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input bit bubble);
        int n;
        logic [18:0]  e;
        logic [127:0] last;
        n = 0;
        last = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        chk1("rdy_qload", in_ready, 1'b1);
        for (int j = 0; n < COL + LEN; j++) begin
            in_valid = !bubble || (j % 2 == 0);
            mem_in   = vec(j);
            tick();
            if (in_valid) begin
                e = (n < LEN) ? (QW | qa(n)) : (KW | qa(n - LEN));
                last = vec(j);
                n++;
            end else begin
                e = '0;
            end
            chk19("load_inst", inst, e);
            chk128("load_mem_out", mem_out, last);
            chk1("load_rdy", in_ready, (n < COL + LEN));
        end
        in_valid = 1'b0;
    endtask

    task automatic kpre_exec(input int exec_cycles);
        logic [18:0] e;
        start = 1'b1;
        for (int c = 0; c <= COL; c++) begin
            tick();
            e = ((c < COL) ? (KR | qa(c)) : 19'd0) | ((c >= 1) ? KL : 19'd0);
            chk19("kpre_inst", inst, e);
            chk1("kpre_busy", busy, 1'b1);
        end
        start = 1'b0;
        for (int c = 0; c < exec_cycles; c++) begin
            tick();
            e = ((c < LEN) ? (QR | qa(c)) : 19'd0) | ((c >= 1) ? EX : 19'd0);
            chk19("exec_inst", inst, e);
        end
    endtask

    task automatic do_drain();
        int nr;
        int nw;
        bit fv;
        bit rd;
        bit prev;
        logic [18:0] e;
        nr = 0;
        nw = 0;
        prev = 1'b0;
        for (int d = 0; d < 18; d++) begin
            fv = (d == 3) || (d == 4) || (d == 9) || (d >= 12);
            fifo_valid = fv;
            tick();
            rd = fv && (nr < LEN);
            e = (rd ? OFR : 19'd0) | (prev ? (PW | pa(nw)) : 19'd0);
            if (prev) nw++;
            if (rd) nr++;
            prev = rd;
            chk19("drain_inst", inst, e);
        end
        fifo_valid = 1'b0;
    endtask

    task automatic acc_div();
        logic [18:0] e;
        for (int c = 0; c <= LEN; c++) begin
            tick();
            e = ((c < LEN) ? (PRD | pa(c)) : 19'd0) | ((c >= 1) ? SA : 19'd0);
            chk19("acc_inst", inst, e);
        end
        for (int k = 0; k < 2 * LEN; k++) begin
            tick();
            e = (k % 2 == 1) ? (SD | PW | pa(k / 2)) : (PRD | pa(k / 2));
            chk19("div_inst", inst, e);
            chk1("div_done", done, (k == 2 * LEN - 1));
            chk1("div_busy", busy, 1'b1);
        end
        tick();
        chk19("post_done_inst", inst, 19'd0);
        chk1("post_done_done", done, 1'b0);
        chk1("post_done_busy", busy, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        in_valid   = 1'b0;
        fifo_valid = 1'b0;
        mem_in     = '0;
        repeat (3) tick();
        chk19("rst_inst", inst, 19'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rdy", in_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk128("rst_mem_out", mem_out, 128'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk1("idle_busy", busy, 1'b0);
        chk19("idle_inst", inst, 19'd0);
`ifdef SEQ_PERF_CNT_EN
        chk19("rst_cycle_cnt", 19'(cycle_cnt), 19'd0);
        chk19("rst_stall_cnt", 19'(stall_cnt), 19'd0);
`endif

        do_load(1'b0);
        kpre_exec(LEN + 1);
        do_drain();
        acc_div();
`ifdef SEQ_PERF_CNT_EN
        chk19("pass1_cycle_cnt", 19'(cycle_cnt), 19'd78);
        chk19("pass1_stall_cnt", 19'(stall_cnt), 19'd9);
`endif

        do_load(1'b1);
`ifdef SEQ_PERF_CNT_EN
        chk19("bubble_cycle_cnt", 19'(cycle_cnt), 19'd31);
        chk19("bubble_stall_cnt", 19'(stall_cnt), 19'd15);
`endif
        kpre_exec(3);
        reset = 1'b1;
        tick();
        chk19("abort_inst", inst, 19'd0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_rdy", in_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk1("abort_idle_busy", busy, 1'b0);
        chk1("abort_idle_done", done, 1'b0);
        chk19("abort_idle_inst", inst, 19'd0);
`ifdef SEQ_PERF_CNT_EN
        chk19("abort_cycle_cnt", 19'(cycle_cnt), 19'd0);
        chk19("abort_stall_cnt", 19'(stall_cnt), 19'd0);
`endif

        do_load(1'b0);
        kpre_exec(LEN + 1);
        do_drain();
        acc_div();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
